// File: rtl/simp_fun_pkg.sv
// Shared definitions for the simp_fun datapath and its front-end arbiter.
package simp_fun_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int SIMP_FUN_LATENCY = 2;
  localparam int MAX_REQ          = 8;
  localparam int TAG_ID_W         = $clog2(MAX_REQ);

  // One entry of the tag pipe that travels alongside an operation.
  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Increment an index and wrap it back to zero at n.
  function automatic int wrapInc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first valid requester
// found when searching upward from the pointer, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  // Walk the requesters starting at the pointer and take the first one valid.
  always_comb begin
    automatic int   idx   = 0;
    automatic logic found = 1'b0;
    o_grant = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && i_valid[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simp_fun_arb.sv
// Round-robin front end that shares one fixed-latency simp_fun datapath among
// NUM_REQ requesters, tagging each operation with its requester ID and routing
// the registered result back to the originator.
module simp_fun_arb
  import simp_fun_pkg::*;
#(
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int NUM_REQ = 4,
  parameter  int LATENCY = SIMP_FUN_LATENCY,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(LATENCY + 2)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         fun_a,
  output logic [WIDTH-1:0]         fun_b,
  input  logic [WIDTH-1:0]         fun_c,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_c,
  output logic                     busy,
  output logic [CNT_W-1:0]         in_flight
);

  logic [NUM_REQ-1:0] w_reqMasked;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grantIdx;
  logic               w_transfer;
  logic               w_retire;
  logic [WIDTH-1:0]   w_selA;
  logic [WIDTH-1:0]   w_selB;

  logic [ID_W-1:0]    r_rrPtr;
  logic [WIDTH-1:0]   r_funA;
  logic [WIDTH-1:0]   r_funB;
  logic               r_issueV;
  logic [ID_W-1:0]    r_issueId;
  tag_t               r_tagPipe [LATENCY];
  logic [NUM_REQ-1:0] r_respValid;
  logic [WIDTH-1:0]   r_respC;
  logic [CNT_W-1:0]   r_inFlight;

  // Dropping en hides every request from the arbiter so nothing new is granted.
  assign w_reqMasked = req_valid & {NUM_REQ{en}};

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .i_valid (w_reqMasked),
    .i_ptr   (r_rrPtr),
    .o_grant (w_grant)
  );

  // Convert the one-hot grant into the requester index used for muxing and tagging.
  always_comb begin
    w_grantIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_grantIdx = ID_W'(i);
    end
  end

  assign w_transfer = |w_grant;
  assign w_retire   = r_tagPipe[LATENCY-1].v;
  assign w_selA     = req_a[w_grantIdx*WIDTH +: WIDTH];
  assign w_selB     = req_b[w_grantIdx*WIDTH +: WIDTH];

  // Round-robin pointer moves just past the requester that was served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
    end else if (w_transfer) begin
      r_rrPtr <= ID_W'(wrapInc(int'(w_grantIdx), NUM_REQ));
    end
  end

  // Issue register: launch the granted operands; operands hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funA    <= '0;
      r_funB    <= '0;
      r_issueV  <= 1'b0;
      r_issueId <= '0;
    end else begin
      r_issueV <= w_transfer;
      if (w_transfer) begin
        r_funA    <= w_selA;
        r_funB    <= w_selB;
        r_issueId <= w_grantIdx;
      end
    end
  end

  // Tag pipe shadows the datapath latency so the ID lines up with fun_c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++) r_tagPipe[k] <= '0;
    end else begin
      r_tagPipe[0] <= '{v: r_issueV, id: TAG_ID_W'(r_issueId)};
      for (int k = 1; k < LATENCY; k++) r_tagPipe[k] <= r_tagPipe[k-1];
    end
  end

  // Response register: strobe the originator and capture the result; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_respValid <= '0;
      r_respC     <= '0;
    end else begin
      r_respValid <= w_retire ? (NUM_REQ'(1) << r_tagPipe[LATENCY-1].id) : '0;
      if (w_retire) r_respC <= fun_c;
    end
  end

  // Outstanding-operation counter: an operation retires on the edge that raises its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inFlight <= '0;
    end else begin
      case ({w_transfer, w_retire})
        2'b10:   r_inFlight <= r_inFlight + CNT_W'(1);
        2'b01:   r_inFlight <= r_inFlight - CNT_W'(1);
        default: r_inFlight <= r_inFlight;
      endcase
    end
  end

  assign req_ready  = w_grant;
  assign fun_a      = r_funA;
  assign fun_b      = r_funB;
  assign resp_valid = r_respValid;
  assign resp_c     = r_respC;
  assign in_flight  = r_inFlight;
  assign busy       = (r_inFlight != '0);

endmodule

// File: doc/simp_fun_arb.md
Name: simp_fun_arb

Overview:
- Round-robin arbiter and sequencer that shares one `simp_fun` pipelined datapath (fixed latency, no stall) among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the datapath.
- Carries the requester ID alongside each operation through a tag pipeline matched to the datapath latency, then routes each registered result back to its originator.
- Sits directly in front of `simp_fun`; both blocks run on the same clk.

Parameters:
- WIDTH, 16, operand/result width (must match the datapath).
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 2, rising edges from the datapath sampling fun_a/fun_b to the result being valid on fun_c.
- ID_W (localparam), $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  issue enable; 0 = no new grants, in-flight work drains.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant (combinational, one-hot or zero).
- req_a  in  NUM_REQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same packing as req_a.
- fun_a  out  WIDTH  operand A to the datapath (registered).
- fun_b  out  WIDTH  operand B to the datapath (registered).
- fun_c  in  WIDTH  datapath result.
- resp_valid  out  NUM_REQ  one-hot, one-cycle response strobe (registered).
- resp_c  out  WIDTH  response data, valid while any resp_valid bit is 1 (registered).
- busy  out  1  1 while any operation is in flight.
- in_flight  out  $clog2(LATENCY+2)  count of accepted operations not yet responded.

Behaviour:
- Reset: all outputs are 0, rr_ptr=0, tag pipe cleared. Assertion mid-operation discards all in-flight work; no resp_valid is produced for it after release.
- Grant: when en=1, req_ready[i]=1 for the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ. When en=0, req_ready=0.
- Transfer: a transfer occurs when req_valid[i]&&req_ready[i]. The requester holds req_a/req_b stable until then.
- Round-robin pointer: on a transfer from i, rr_ptr <= (i+1) mod NUM_REQ. Without a transfer, rr_ptr holds.
- Issue register: on a transfer at edge N, fun_a/fun_b <= the granted operands, issue_v<=1, issue_id<=i. With no transfer, issue_v<=0 and fun_a/fun_b hold their previous values.
- Tag pipe: LATENCY stages of {v, id}. Stage 0 <= {issue_v, issue_id}; stage k <= stage k-1. The pipe shifts every cycle with no stall.
- Response register: at edge N+LATENCY+1, resp_valid[id] <= stage[LATENCY-1].v, and resp_c <= fun_c if that v=1, else resp_c holds.
- Latency: accept at edge N → resp_valid high in the cycle after edge N+LATENCY+1 (N+3 for LATENCY=2).
- Throughput: one transfer per cycle, sustained. Responses return in issue order.
- Response handshake: there is no response-side ready; requesters must accept resp_valid unconditionally.
- in_flight: +1 on transfer, −1 on resp_valid; both in the same cycle leaves it unchanged. Maximum value is LATENCY+1.
- busy = (in_flight != 0).
- en deasserted mid-stream: no new grants, tags keep shifting, all outstanding responses still arrive, busy falls after the last one.
- Wrap-around: the search from rr_ptr=NUM_REQ-1 continues at 0. A sole requester re-granted every cycle gets 100% of the slots.

Decomposition:
- Package simp_fun_pkg holds:
  - localparams DEFAULT_WIDTH=16 and SIMP_FUN_LATENCY=2;
  - typedef tag_t = struct {logic v; logic [ID_W-1:0] id;}, with ID_W sized for a max of 8 requesters.
- One sub-module, rr_arbiter: parameter N; inputs valid[N], ptr; output grant one-hot. Purely combinational priority rotation, reusable elsewhere.
- Tag pipe, response register and counters stay in the top module.

Test Plan:
- Single requester: rst_n low 3 cycles, release; req 0 sends a=5, b=7 at edge N → req_ready[0]=1 at N, fun_a=5/fun_b=7 after N, resp_valid=4'b0001 with resp_c = reference model(5,7) after edge N+3; in_flight 1→0.
- All four continuously valid with a=i*10, b=i*10+1 → grant order 0,1,2,3,0,1…; every cycle one transfer; resp_valid sequence 0001,0010,0100,1000 from N+3 with matching results.
- Requesters 1 and 3 valid, rr_ptr=2 → req 3 granted first, then 1 (wrap-around), then 3.
- en dropped for 4 cycles after three back-to-back transfers → req_ready=0 during those cycles, 3 responses still arrive, busy deasserts after the third, then grants resume from rr_ptr.
- rst_n pulsed low one cycle after two transfers → no resp_valid ever for them; in_flight=0, fun_a=0, fun_b=0, rr_ptr=0 after reset.
- Operands 0/0 and 255/255 from req 2 → results routed only to resp_valid[2]; resp_c holds its value on idle cycles.
